// File: rtl/c7bexu_hzdctl_pkg.sv
// Shared types and constants for the c7bexu hazard/bypass controller.
// Holds the MDU FSM encoding and the M-stage control word layout.
package c7bexu_pkg;

    localparam int         STALL_CNT_W = 16;
    localparam logic [4:0] REG_X0      = 5'd0;

    typedef logic [1:0] mdu_state_t;
    localparam mdu_state_t MDU_IDLE = 2'd0;
    localparam mdu_state_t MDU_BUSY = 2'd1;
    localparam mdu_state_t MDU_DONE = 2'd2;

    // M-stage control word: destination, effective write enable, load flag
    typedef struct packed {
        logic [4:0] rd;
        logic       wen;
        logic       load;
    } pipe_ctl_t;

    localparam pipe_ctl_t PIPE_BUBBLE = '{rd: REG_X0, wen: 1'b0, load: 1'b0};

endpackage

// File: rtl/c7bexu_hzdctl_if.sv
// E-stage control inputs and bypass/stall outputs of the hazard controller.
// The controller is the slave; the decode/execute side is the master.
interface c7bexu_hzdctl_if;
    import c7bexu_pkg::*;

    logic                   valid_e;
    logic [4:0]             rs1_e;
    logic [4:0]             rs2_e;
    logic                   rs1_used_e;
    logic                   rs2_used_e;
    logic [4:0]             rd_e;
    logic                   wen_e;
    logic                   load_e;
    logic                   mdu_e;
    logic                   mdu_done;
    logic                   flush_e;
    logic                   dmem_wait;
    logic [4:0]             rd_m;
    logic [4:0]             rd_w;
    logic                   wen_m;
    logic                   wen_w;
    logic                   stall_e;
    logic                   mdu_start;
    logic                   mdu_kill;
    logic [STALL_CNT_W-1:0] stall_cnt;

    modport master (
        output valid_e, rs1_e, rs2_e, rs1_used_e, rs2_used_e, rd_e, wen_e,
               load_e, mdu_e, mdu_done, flush_e, dmem_wait,
        input  rd_m, rd_w, wen_m, wen_w, stall_e, mdu_start, mdu_kill, stall_cnt
    );

    modport slave (
        input  valid_e, rs1_e, rs2_e, rs1_used_e, rs2_used_e, rd_e, wen_e,
               load_e, mdu_e, mdu_done, flush_e, dmem_wait,
        output rd_m, rd_w, wen_m, wen_w, stall_e, mdu_start, mdu_kill, stall_cnt
    );

endinterface

// File: rtl/c7bexu_hzdctl_hzdcmp.sv
// Per-operand load-use compare: flags a source that reads the pending
// destination of a load sitting in M (x0 never hazards).
module c7bexu_hzdcmp
    import c7bexu_pkg::*;
(
    input  logic [4:0] rs,
    input  logic       used,
    input  logic [4:0] rd_m,
    input  logic       wen_m,
    input  logic       load_m,
    output logic       hazard
);

    assign hazard = used && (rs == rd_m) && (rs != REG_X0) && wen_m && load_m;

endmodule

// File: rtl/c7bexu_hzdctl.sv
// Hazard and bypass controller: owns the M/W control registers, stalls E on
// load-use and MDU occupancy, and counts stall cycles.
module c7bexu_hzdctl
    import c7bexu_pkg::*;
(
    input  logic            clk,
    input  logic            resetn,
    c7bexu_hzdctl_if.slave  hif
);

    pipe_ctl_t              m_q;
    pipe_ctl_t              m_d;
    logic [4:0]             rd_w_q;
    logic                   wen_w_q;
    mdu_state_t             state_q;
    mdu_state_t             state_d;
    logic [STALL_CNT_W-1:0] cnt_q;

    logic hz_rs1;
    logic hz_rs2;
    logic load_use;
    logic launch;
    logic stall;
    logic advance;

    c7bexu_hzdcmp u_cmp_rs1 (
        .rs     (hif.rs1_e),
        .used   (hif.rs1_used_e),
        .rd_m   (m_q.rd),
        .wen_m  (m_q.wen),
        .load_m (m_q.load),
        .hazard (hz_rs1)
    );

    c7bexu_hzdcmp u_cmp_rs2 (
        .rs     (hif.rs2_e),
        .used   (hif.rs2_used_e),
        .rd_m   (m_q.rd),
        .wen_m  (m_q.wen),
        .load_m (m_q.load),
        .hazard (hz_rs2)
    );

    assign load_use = hif.valid_e && (hz_rs1 || hz_rs2);

    // Memory wait and load-use both take priority over starting the MDU.
    assign launch = (state_q == MDU_IDLE) && hif.valid_e && hif.mdu_e && !load_use
                    && !hif.flush_e && !hif.dmem_wait;

    // A flush overrides every stall source; reset forces the strobes low.
    assign stall = resetn && !hif.flush_e
                   && (hif.dmem_wait || load_use || launch || (state_q == MDU_BUSY));

    assign advance = hif.valid_e && !hif.flush_e && !stall;

    // NOTE: every variable written here gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        if (hif.flush_e) begin
            state_d = MDU_IDLE;
        end else begin
            case (state_q)
                MDU_IDLE: if (launch)       state_d = MDU_BUSY;
                MDU_BUSY: if (hif.mdu_done) state_d = MDU_DONE;
                MDU_DONE: if (advance)      state_d = MDU_IDLE;
                default:                    state_d = MDU_IDLE;
            endcase
        end
    end

    always_comb begin
        m_d = PIPE_BUBBLE;
        if (advance) begin
            m_d.rd   = hif.rd_e;
            m_d.wen  = hif.wen_e && (hif.rd_e != REG_X0);
            m_d.load = hif.load_e;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_q     <= PIPE_BUBBLE;
            rd_w_q  <= REG_X0;
            wen_w_q <= 1'b0;
            state_q <= MDU_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (!hif.dmem_wait) begin
                rd_w_q  <= m_q.rd;
                wen_w_q <= m_q.wen;
                m_q     <= m_d;
            end
            if (stall && (cnt_q != {STALL_CNT_W{1'b1}})) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign hif.rd_m      = m_q.rd;
    assign hif.wen_m     = m_q.wen;
    assign hif.rd_w      = rd_w_q;
    assign hif.wen_w     = wen_w_q;
    assign hif.stall_e   = stall;
    assign hif.mdu_start = resetn && launch;
    assign hif.mdu_kill  = resetn && (state_q == MDU_BUSY) && hif.flush_e;
    assign hif.stall_cnt = cnt_q;

endmodule

// File: tb/tb_c7bexu_hzdctl.sv
// Self-checking bench for c7bexu_hzdctl: directed scenarios with fixed
// expectations plus a randomized run against a pipeline-level model.
module tb_c7bexu_hzdctl;

    logic clk = 1'b0;
    logic resetn;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    c7bexu_hzdctl_if hif ();

    c7bexu_hzdctl dut (
        .clk    (clk),
        .resetn (resetn),
        .hif    (hif)
    );

    wire [30:0] obs = {hif.rd_m, hif.wen_m, hif.rd_w, hif.wen_w, hif.stall_e,
                       hif.mdu_start, hif.mdu_kill, hif.stall_cnt};

    // Model: M/W contents, MDU "result pending" flags, stall counter
    logic [4:0] m_rd, w_rd;
    logic       m_wen, m_load, w_wen;
    logic       mdl_busy, mdl_ready;
    int         mdl_cnt;
    logic       e_stall, e_launch, e_kill, e_adv;
    logic [30:0] exp_vec;

    task automatic model_reset();
        m_rd = 0; m_wen = 0; m_load = 0; w_rd = 0; w_wen = 0;
        mdl_busy = 0; mdl_ready = 0; mdl_cnt = 0;
    endtask

    task automatic model_eval();
        logic hz;
        logic [15:0] c;
        hz = hif.valid_e && m_wen && m_load &&
             ((hif.rs1_used_e && hif.rs1_e == m_rd && hif.rs1_e != 0) ||
              (hif.rs2_used_e && hif.rs2_e == m_rd && hif.rs2_e != 0));
        e_launch = resetn && !mdl_busy && !mdl_ready && hif.valid_e && hif.mdu_e &&
                   !hz && !hif.flush_e && !hif.dmem_wait;
        e_stall  = resetn && !hif.flush_e && (hif.dmem_wait || hz || e_launch || mdl_busy);
        e_kill   = resetn && mdl_busy && hif.flush_e;
        e_adv    = hif.valid_e && !hif.flush_e && !e_stall;
        c = mdl_cnt[15:0];
        exp_vec = {m_rd, m_wen, w_rd, w_wen, e_stall, e_launch, e_kill, c};
    endtask

    task automatic model_update();
        if (!resetn) begin
            model_reset();
        end else begin
            if (hif.flush_e) begin
                mdl_busy = 0; mdl_ready = 0;
            end else if (mdl_busy && hif.mdu_done) begin
                mdl_busy = 0; mdl_ready = 1;
            end else if (e_launch) begin
                mdl_busy = 1;
            end else if (mdl_ready && e_adv) begin
                mdl_ready = 0;
            end
            if (!hif.dmem_wait) begin
                w_rd = m_rd; w_wen = m_wen;
                if (e_adv) begin
                    m_rd = hif.rd_e; m_wen = hif.wen_e && (hif.rd_e != 0); m_load = hif.load_e;
                end else begin
                    m_rd = 0; m_wen = 0; m_load = 0;
                end
            end
            if (e_stall && mdl_cnt < 65535) mdl_cnt++;
        end
    endtask

    task automatic eval_now();
        #1;
        model_eval();
    endtask

    task automatic tick();
        eval_now();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        hif.valid_e = 0; hif.rs1_e = 0; hif.rs2_e = 0; hif.rs1_used_e = 0;
        hif.rs2_used_e = 0; hif.rd_e = 0; hif.wen_e = 0; hif.load_e = 0;
        hif.mdu_e = 0; hif.mdu_done = 0; hif.flush_e = 0; hif.dmem_wait = 0;
    endtask

    task automatic set_e(input logic v, input logic [4:0] rs1, input logic u1,
                         input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                         input logic wen, input logic ld, input logic mdu);
        hif.valid_e = v; hif.rs1_e = rs1; hif.rs1_used_e = u1; hif.rs2_e = rs2;
        hif.rs2_used_e = u2; hif.rd_e = rd; hif.wen_e = wen; hif.load_e = ld; hif.mdu_e = mdu;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        resetn = 0;
        model_reset();
        @(negedge clk);
        resetn = 1;
    endtask

    task automatic test_reset();
        resetn = 0;
        model_reset();
        set_e(1, 1, 1, 2, 1, 3, 1, 0, 1);
        #1;
        total++;
        if (obs !== 31'd0) begin
            bad++; $display("FAIL reset_outputs got=%h exp=0", obs);
        end
        idle_inputs();
        @(negedge clk);
        resetn = 1;
        eval_now();
        total++;
        if (obs !== 31'd0) begin
            bad++; $display("FAIL reset_release got=%h exp=0", obs);
        end
    endtask

    task automatic test_load_use();
        do_reset();
        set_e(1, 0, 0, 0, 0, 5, 1, 1, 0);
        eval_now();
        total++;
        if (hif.stall_e !== 1'b0) begin bad++; $display("FAIL lu_load_issue stall got=%b exp=0", hif.stall_e); end
        tick();
        set_e(1, 5, 1, 0, 0, 6, 1, 0, 0);
        eval_now();
        total++;
        if ({hif.rd_m, hif.wen_m} !== {5'd5, 1'b1}) begin bad++; $display("FAIL lu_load_in_m got=%0d/%b exp=5/1", hif.rd_m, hif.wen_m); end
        total++;
        if (hif.stall_e !== 1'b1) begin bad++; $display("FAIL lu_stall got=%b exp=1", hif.stall_e); end
        tick();
        eval_now();
        total++;
        if ({hif.wen_m, hif.rd_w, hif.wen_w, hif.stall_e} !== {1'b0, 5'd5, 1'b1, 1'b0}) begin
            bad++; $display("FAIL lu_bubble wen_m=%b rd_w=%0d wen_w=%b stall=%b exp=0/5/1/0",
                            hif.wen_m, hif.rd_w, hif.wen_w, hif.stall_e);
        end
        tick();
        idle_inputs();
        eval_now();
        total++;
        if ({hif.rd_m, hif.wen_m, hif.stall_cnt} !== {5'd6, 1'b1, 16'd1}) begin
            bad++; $display("FAIL lu_after rd_m=%0d wen_m=%b cnt=%0d exp=6/1/1", hif.rd_m, hif.wen_m, hif.stall_cnt);
        end
    endtask

    task automatic test_x0();
        do_reset();
        set_e(1, 0, 0, 0, 0, 0, 1, 0, 0);
        tick();
        set_e(1, 0, 1, 0, 1, 4, 1, 0, 0);
        eval_now();
        total++;
        if ({hif.wen_m, hif.stall_e} !== 2'b00) begin bad++; $display("FAIL x0_alu wen_m=%b stall=%b exp=0/0", hif.wen_m, hif.stall_e); end
        tick();
        set_e(1, 0, 0, 0, 0, 0, 1, 1, 0);
        tick();
        set_e(1, 0, 1, 0, 1, 4, 1, 0, 0);
        eval_now();
        total++;
        if ({hif.wen_m, hif.stall_e} !== 2'b00) begin bad++; $display("FAIL x0_load wen_m=%b stall=%b exp=0/0", hif.wen_m, hif.stall_e); end
        tick();
        idle_inputs();
    endtask

    task automatic test_mdu();
        do_reset();
        set_e(1, 1, 1, 2, 1, 7, 1, 0, 1);
        for (int k = 0; k <= 5; k++) begin
            hif.mdu_done = (k == 4);
            eval_now();
            total++;
            if ({hif.stall_e, hif.mdu_start, hif.mdu_kill} !== {k < 5, k == 0, 1'b0}) begin
                bad++; $display("FAIL mdu_cycle%0d stall/start/kill got=%b%b%b exp=%b%b0",
                                k, hif.stall_e, hif.mdu_start, hif.mdu_kill, k < 5, k == 0);
            end
            tick();
        end
        idle_inputs();
        eval_now();
        total++;
        if ({hif.rd_m, hif.wen_m, hif.stall_cnt} !== {5'd7, 1'b1, 16'd5}) begin
            bad++; $display("FAIL mdu_result rd_m=%0d wen_m=%b cnt=%0d exp=7/1/5", hif.rd_m, hif.wen_m, hif.stall_cnt);
        end
    endtask

    task automatic test_flush_mdu();
        do_reset();
        set_e(1, 1, 1, 0, 0, 9, 1, 0, 1);
        tick();
        tick();
        hif.flush_e = 1; hif.mdu_done = 1;
        eval_now();
        total++;
        if ({hif.mdu_kill, hif.stall_e, hif.mdu_start} !== 3'b100) begin
            bad++; $display("FAIL flush_kill kill/stall/start got=%b%b%b exp=100", hif.mdu_kill, hif.stall_e, hif.mdu_start);
        end
        tick();
        idle_inputs();
        eval_now();
        total++;
        if ({hif.wen_m, hif.stall_e} !== 2'b00) begin bad++; $display("FAIL flush_bubble wen_m=%b stall=%b exp=0/0", hif.wen_m, hif.stall_e); end
        tick();
        set_e(1, 1, 1, 0, 0, 9, 1, 0, 1);
        eval_now();
        total++;
        if ({hif.wen_w, hif.mdu_start} !== 2'b01) begin bad++; $display("FAIL flush_idle wen_w=%b start=%b exp=0/1", hif.wen_w, hif.mdu_start); end
        hif.flush_e = 1;
        tick();
        idle_inputs();
    endtask

    task automatic test_dmem_wait();
        do_reset();
        set_e(1, 0, 0, 0, 0, 3, 1, 0, 0);
        tick();
        set_e(1, 0, 0, 0, 0, 5, 1, 1, 0);
        tick();
        set_e(1, 5, 1, 0, 0, 6, 1, 0, 0);
        hif.dmem_wait = 1;
        for (int k = 0; k < 3; k++) begin
            eval_now();
            total++;
            if ({hif.rd_m, hif.wen_m, hif.rd_w, hif.wen_w, hif.stall_e} !== {5'd5, 1'b1, 5'd3, 1'b1, 1'b1}) begin
                bad++; $display("FAIL dmem_freeze%0d rd_m=%0d rd_w=%0d stall=%b exp=5/3/1", k, hif.rd_m, hif.rd_w, hif.stall_e);
            end
            tick();
        end
        hif.dmem_wait = 0;
        eval_now();
        total++;
        if (hif.stall_e !== 1'b1) begin bad++; $display("FAIL dmem_then_lu stall got=%b exp=1", hif.stall_e); end
        tick();
        eval_now();
        total++;
        if ({hif.stall_e, hif.wen_m, hif.rd_w, hif.wen_w, hif.stall_cnt} !== {1'b0, 1'b0, 5'd5, 1'b1, 16'd4}) begin
            bad++; $display("FAIL dmem_release stall=%b wen_m=%b rd_w=%0d cnt=%0d exp=0/0/5/4",
                            hif.stall_e, hif.wen_m, hif.rd_w, hif.stall_cnt);
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_saturation();
        do_reset();
        hif.dmem_wait = 1;
        repeat (65534) tick();
        eval_now();
        total++;
        if (hif.stall_cnt !== 16'hFFFE) begin bad++; $display("FAIL sat_before got=%h exp=fffe", hif.stall_cnt); end
        tick();
        eval_now();
        total++;
        if (hif.stall_cnt !== 16'hFFFF) begin bad++; $display("FAIL sat_reach got=%h exp=ffff", hif.stall_cnt); end
        repeat (4465) tick();
        eval_now();
        total++;
        if (hif.stall_cnt !== 16'hFFFF) begin bad++; $display("FAIL sat_hold got=%h exp=ffff", hif.stall_cnt); end
        set_e(1, 1, 1, 0, 0, 2, 1, 0, 1);
        resetn = 0;
        model_reset();
        #1;
        total++;
        if (obs !== 31'd0) begin bad++; $display("FAIL sat_reset got=%h exp=0", obs); end
    endtask

    task automatic test_reset_mid_mdu();
        @(negedge clk);
        resetn = 1;
        idle_inputs();
        set_e(1, 1, 1, 0, 0, 8, 1, 0, 1);
        eval_now();
        total++;
        if (hif.mdu_start !== 1'b1) begin bad++; $display("FAIL rst_mdu_start got=%b exp=1", hif.mdu_start); end
        tick();
        eval_now();
        total++;
        if (hif.stall_e !== 1'b1) begin bad++; $display("FAIL rst_mdu_busy stall got=%b exp=1", hif.stall_e); end
        hif.flush_e = 1;
        resetn = 0;
        model_reset();
        #1;
        total++;
        if (obs !== 31'd0) begin bad++; $display("FAIL rst_mdu_kill got=%h exp=0", obs); end
        @(negedge clk);
        hif.flush_e = 0;
        resetn = 1;
        eval_now();
        total++;
        if (hif.mdu_start !== 1'b1) begin bad++; $display("FAIL rst_mdu_idle start got=%b exp=1", hif.mdu_start); end
        hif.flush_e = 1;
        tick();
        idle_inputs();
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                idle_inputs();
                resetn = 0;
                model_reset();
            end else begin
                resetn = 1;
                set_e($urandom_range(0, 9) < 8, 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                      5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                      1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0);
                hif.mdu_done  = $urandom_range(0, 9) < 3;
                hif.flush_e   = $urandom_range(0, 19) == 0;
                hif.dmem_wait = $urandom_range(0, 9) == 0;
            end
            eval_now();
            total++;
            if (obs !== exp_vec) begin
                bad++; $display("FAIL random_cycle%0d got=%h exp=%h", n, obs, exp_vec);
            end
            tick();
        end
        resetn = 1;
        idle_inputs();
    endtask

    initial begin
        resetn = 0;
        idle_inputs();
        model_reset();
        repeat (2) @(negedge clk);
        test_reset();
        test_load_use();
        test_x0();
        test_mdu();
        test_flush_mdu();
        test_dmem_wait();
        test_random();
        test_saturation();
        test_reset_mid_mdu();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
